dft64_loader: RTL

DFT64_LOADER -- requirements
Module: dft64_loader

---
 rtl/dft64_pkg.sv | 15 +
 rtl/dft64_loader_if.sv | 21 ++
 rtl/dft64_frame_buf.sv | 35 +++
 rtl/dft64_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dft64_pkg.sv
// Shared constants, sample type and sender state encoding for the dft64 frame loader.
package dft64_pkg;
  localparam int SAMPLE_W     = 16;
  localparam int LANES        = 8;
  localparam int FRAME        = 64;
  localparam int DONE_TIMEOUT = 6;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } send_state_e;
endpackage

// File: rtl/dft64_loader_if.sv
// Sample stream in, packed beats out, done back from the dft64 core.
interface dft64_loader_if;
  import dft64_pkg::*;

  logic                      s_valid;
  logic                      s_ready;
  sample_t                   s_data;
  logic [LANES*SAMPLE_W-1:0] samples;
  logic                      rel;
  logic                      done;

  modport slave (
    input  s_valid, s_data, done,
    output s_ready, samples, rel
  );

  modport master (
    output s_valid, s_data, done,
    input  s_ready, samples, rel
  );
endinterface

// File: rtl/dft64_frame_buf.sv
// Two-bank sample store: one sample written per cycle, one full beat of LANES samples read.
module dft64_frame_buf #(
  parameter int SAMPLE_W = dft64_pkg::SAMPLE_W,
  parameter int LANES    = dft64_pkg::LANES,
  parameter int FRAME    = dft64_pkg::FRAME
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic                         wr_bank,
  input  logic [$clog2(FRAME)-1:0]     wr_idx,
  input  logic [SAMPLE_W-1:0]          wr_data,
  input  logic                         rd_bank,
  input  logic [$clog2(FRAME/LANES)-1:0] rd_beat,
  output logic [LANES*SAMPLE_W-1:0]    rd_data
);
  import dft64_pkg::*;

  localparam int LANE_W = $clog2(LANES);

  logic [SAMPLE_W-1:0] mem_q [2*FRAME];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_idx}] <= wr_data;
    end
  end

  // Lane 0 (the earliest sample of the beat) lands in the most significant slot.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data[(LANES-1-i)*SAMPLE_W +: SAMPLE_W] = mem_q[{rd_bank, rd_beat, LANE_W'(i)}];
    end
  end
endmodule

// File: rtl/dft64_loader.sv
// Ping-pong frame loader: buffers 64-sample frames and streams each as 8 packed beats to dft64.
module dft64_loader #(
  parameter int SAMPLE_W     = dft64_pkg::SAMPLE_W,
  parameter int LANES        = dft64_pkg::LANES,
  parameter int FRAME        = dft64_pkg::FRAME,
  parameter int DONE_TIMEOUT = dft64_pkg::DONE_TIMEOUT
) (
  input  logic          clk,
  input  logic          areset_n,
  dft64_loader_if.slave bus,
  output logic          busy,
  output logic          err_timeout
);
  import dft64_pkg::*;

  localparam int IDX_W  = $clog2(FRAME);
  localparam int BEAT_W = $clog2(FRAME / LANES);
  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
  localparam int DATA_W = LANES * SAMPLE_W;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME / LANES - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(DONE_TIMEOUT - 1);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] SEND      = ST_SEND;
  localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [BEAT_W-1:0] beat_q, beat_d, rd_beat;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rel_q, rel_d;
  logic [DATA_W-1:0] samples_q, samples_d, rd_data;
  logic              s_ready, accept, release_bank;

  // Reset asserts asynchronously but releases two clock edges later.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign s_ready = !(full_q[0] && full_q[1]);
  assign accept  = bus.s_valid && s_ready;
  assign rd_beat = (state_q == SEND) ? beat_q + 1'b1 : '0;

  dft64_frame_buf #(
    .SAMPLE_W (SAMPLE_W),
    .LANES    (LANES),
    .FRAME    (FRAME)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wr_bank_q),
    .wr_idx  (wr_idx_q),
    .wr_data (bus.s_data),
    .rd_bank (rd_bank_q),
    .rd_beat (rd_beat),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    rel_d        = 1'b0;
    samples_d    = samples_q;
    release_bank = 1'b0;

    if (accept) begin
      wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = SEND;
          beat_d    = '0;
          rel_d     = 1'b1;
          samples_d = rd_data;
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          state_d = WAIT_DONE;
          wait_d  = '0;
        end else begin
          beat_d    = beat_q + 1'b1;
          rel_d     = 1'b1;
          samples_d = rd_data;
        end
      end
      WAIT_DONE: begin
        if (bus.done || wait_q == LAST_WAIT) release_bank = 1'b1;
        else                                 wait_d       = wait_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The bank being released is never the one that just completed filling.
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      state_d           = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      beat_q    <= '0;
      wait_q    <= '0;
      rel_q     <= 1'b0;
      samples_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      rel_q     <= rel_d;
      samples_q <= samples_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.rel      = rel_q;
  assign bus.samples  = samples_q;
  assign busy         = (state_q == SEND) || (state_q == WAIT_DONE);
  assign err_timeout  = (state_q == WAIT_DONE) && !bus.done && (wait_q == LAST_WAIT);
endmodule
